// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush controller.
// The controller side takes the master modport; the datapath (or bench) takes slave.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_dmem_req;
    logic             mem_dmem_ready;
    logic             cnt_clr;
    logic             pc_write;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_enable;
    logic             id_ex_flush;
    logic             ex_mem_enable;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             mem_timeout;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
        input  mem_dmem_req, mem_dmem_ready, cnt_clr,
        output pc_write, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
        output ex_mem_enable, mem_wb_bubble, stall_cycles, flush_events, mem_timeout
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
        output mem_dmem_req, mem_dmem_ready, cnt_clr,
        input  pc_write, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
        input  ex_mem_enable, mem_wb_bubble, stall_cycles, flush_events, mem_timeout
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage core: prioritises mem-wait, taken branch and
// load-use hazards into register enables/flushes, with a mem-wait watchdog and counters.
module pipeline_stall_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic                           clk,
    input logic                           rst,
    pipeline_stall_controller_if.master   bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              timeout_flag;

    logic load_use;
    logic mem_wait;
    logic stall_inc;
    logic flush_inc;
    logic timeout_set;

    logic pc_write;
    logic if_id_enable;
    logic if_id_flush;
    logic id_ex_enable;
    logic id_ex_flush;
    logic ex_mem_enable;
    logic mem_wb_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign load_use = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                       (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    // A dropped request without ready is treated as completion, so only req&~ready waits.
    assign mem_wait = bus.mem_dmem_req && !bus.mem_dmem_ready;

    always_comb begin
        pc_write      = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_enable = 1'b1;
        mem_wb_bubble = 1'b0;
        state_nxt     = RUN;
        wait_nxt      = '0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        timeout_set   = 1'b0;

        if (rst) begin
            pc_write      = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_wait) begin
            // Freeze everything up to MEM; branch/load-use re-present once EX is released.
            pc_write      = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_bubble = 1'b1;
            stall_inc     = 1'b1;
            state_nxt     = MEM_WAIT;
            case (state)
                RUN:      wait_nxt = WAIT_W'(1);
                MEM_WAIT: wait_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;
                default:  wait_nxt = WAIT_W'(1);
            endcase
            timeout_set = (wait_nxt == WAIT_MAX);
        end else if (bus.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (bus.cnt_clr) begin
                stall_cnt    <= '0;
                flush_cnt    <= '0;
                timeout_flag <= 1'b0;
            end else begin
                if (stall_inc)   stall_cnt    <= sat_inc(stall_cnt);
                if (flush_inc)   flush_cnt    <= sat_inc(flush_cnt);
                if (timeout_set) timeout_flag <= 1'b1;
            end
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.if_id_enable  = if_id_enable;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_enable  = id_ex_enable;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.ex_mem_enable = ex_mem_enable;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.stall_cycles  = stall_cnt;
    assign bus.flush_events  = flush_cnt;
    assign bus.mem_timeout   = timeout_flag;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: one wide-counter/short-timeout instance and one 2-bit-counter instance
// driven by the same stimulus, checked against hand-computed vectors.
module tb_pipeline_stall_controller;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Control vector order: {pc_write, if_id_enable, if_id_flush, id_ex_enable,
    //                        id_ex_flush, ex_mem_enable, mem_wb_bubble}
    localparam logic [6:0] V_DEF = 7'b1101010;
    localparam logic [6:0] V_FRZ = 7'b0000001;
    localparam logic [6:0] V_RST = 7'b0010101;
    localparam logic [6:0] V_LU  = 7'b0001110;
    localparam logic [6:0] V_BR  = 7'b1111110;

    pipeline_stall_controller_if #(.CNT_W(16)) if_a ();
    pipeline_stall_controller_if #(.CNT_W(2))  if_b ();

    pipeline_stall_controller #(.CNT_W(16), .TIMEOUT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.master)
    );

    pipeline_stall_controller #(.CNT_W(2), .TIMEOUT(64)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.master)
    );

    assign if_b.id_rs1          = if_a.id_rs1;
    assign if_b.id_rs2          = if_a.id_rs2;
    assign if_b.id_uses_rs1     = if_a.id_uses_rs1;
    assign if_b.id_uses_rs2     = if_a.id_uses_rs2;
    assign if_b.ex_mem_read     = if_a.ex_mem_read;
    assign if_b.ex_reg_write    = if_a.ex_reg_write;
    assign if_b.ex_rd           = if_a.ex_rd;
    assign if_b.ex_branch_taken = if_a.ex_branch_taken;
    assign if_b.mem_dmem_req    = if_a.mem_dmem_req;
    assign if_b.mem_dmem_ready  = if_a.mem_dmem_ready;
    assign if_b.cnt_clr         = if_a.cnt_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_a();
        return {if_a.pc_write, if_a.if_id_enable, if_a.if_id_flush, if_a.id_ex_enable,
                if_a.id_ex_flush, if_a.ex_mem_enable, if_a.mem_wb_bubble};
    endfunction

    function automatic logic [6:0] ctl_b();
        return {if_b.pc_write, if_b.if_id_enable, if_b.if_id_flush, if_b.id_ex_enable,
                if_b.id_ex_flush, if_b.ex_mem_enable, if_b.mem_wb_bubble};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_a.id_rs1          = 5'd0;
        if_a.id_rs2          = 5'd0;
        if_a.id_uses_rs1     = 1'b0;
        if_a.id_uses_rs2     = 1'b0;
        if_a.ex_mem_read     = 1'b0;
        if_a.ex_reg_write    = 1'b0;
        if_a.ex_rd           = 5'd0;
        if_a.ex_branch_taken = 1'b0;
        if_a.mem_dmem_req    = 1'b0;
        if_a.mem_dmem_ready  = 1'b0;
        if_a.cnt_clr         = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2);
        if_a.ex_mem_read  = 1'b1;
        if_a.ex_reg_write = 1'b1;
        if_a.ex_rd        = rd;
        if_a.id_rs1       = rs1;
        if_a.id_rs2       = rs2;
        if_a.id_uses_rs1  = u1;
        if_a.id_uses_rs2  = u2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_ctl_a", ctl_a(), V_RST);
        check("rst_ctl_b", ctl_b(), V_RST);
        check("rst_stall", if_a.stall_cycles, 0);
        check("rst_flush", if_a.flush_events, 0);
        check("rst_tmo", if_a.mem_timeout, 0);

        rst = 1'b0;
        #1;
        check("idle_def", ctl_a(), V_DEF);

        // x0 destination and unused source never stall
        set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1 check("x0_nostall", ctl_a(), V_DEF);
        tick();
        set_load(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
        #1 check("unused_rs2", ctl_a(), V_DEF);
        tick();
        check("x0_stall_cnt", if_a.stall_cycles, 0);

        // single load-use bubble
        set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        #1 check("lu_ctl", ctl_a(), V_LU);
        tick();
        if_a.ex_mem_read = 1'b0;
        #1 check("lu_next_def", ctl_a(), V_DEF);
        check("lu_stall_cnt", if_a.stall_cycles, 1);
        idle();
        if_a.cnt_clr = 1'b1;
        tick();
        if_a.cnt_clr = 1'b0;
        check("clr_stall", if_a.stall_cycles, 0);

        // branch beats same-cycle load-use
        set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        if_a.ex_branch_taken = 1'b1;
        #1 check("br_vs_lu", ctl_a(), V_BR);
        tick();
        idle();
        check("br_flush_cnt", if_a.flush_events, 1);
        check("br_stall_cnt", if_a.stall_cycles, 0);

        // hazard on both sources gives one bubble
        set_load(5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
        #1 check("lu_both_ctl", ctl_a(), V_LU);
        tick();
        idle();
        check("lu_both_cnt", if_a.stall_cycles, 1);

        // three-cycle memory wait, branch resolved in the ready cycle
        if_a.mem_dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_freeze", ctl_a(), V_FRZ);
            tick();
        end
        if_a.mem_dmem_ready  = 1'b1;
        if_a.ex_branch_taken = 1'b1;
        #1 check("mw_ready_br", ctl_a(), V_BR);
        tick();
        idle();
        #1 check("mw_after_def", ctl_a(), V_DEF);
        check("mw_stall_cnt", if_a.stall_cycles, 4);
        check("mw_flush_cnt", if_a.flush_events, 2);
        check("mw_no_tmo", if_a.mem_timeout, 0);

        // watchdog: six wait cycles with TIMEOUT=4 on dut_a
        if_a.mem_dmem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            #1 check("wd_freeze", ctl_a(), V_FRZ);
            tick();
            if (i == 3) check("wd_tmo_pre", if_a.mem_timeout, 0);
            if (i == 4) check("wd_tmo_rise", if_a.mem_timeout, 1);
        end
        if_a.mem_dmem_ready = 1'b1;
        #1 check("wd_ready_def", ctl_a(), V_DEF);
        tick();
        idle();
        check("wd_tmo_sticky", if_a.mem_timeout, 1);
        check("wd_stall_a", if_a.stall_cycles, 10);
        check("wd_stall_b_sat", if_b.stall_cycles, 3);
        check("wd_flush_b", if_b.flush_events, 2);
        check("wd_tmo_b", if_b.mem_timeout, 0);

        // clear wins over a same-cycle increment
        set_load(5'd9, 5'd0, 5'd9, 1'b0, 1'b1);
        if_a.cnt_clr = 1'b1;
        #1 check("clr_lu_ctl", ctl_a(), V_LU);
        tick();
        if_a.cnt_clr = 1'b0;
        check("clr_win_stall", if_a.stall_cycles, 0);
        check("clr_win_tmo", if_a.mem_timeout, 0);
        check("clr_win_flush", if_a.flush_events, 0);

        // five load-use cycles saturate the 2-bit counter
        for (int i = 0; i < 5; i++) tick();
        idle();
        check("sat_stall_a", if_a.stall_cycles, 5);
        check("sat_stall_b", if_b.stall_cycles, 3);

        // reset in the middle of a memory wait
        if_a.mem_dmem_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1 check("rst_mw_ctl", ctl_a(), V_RST);
        tick();
        check("rst_mw_ctl2", ctl_a(), V_RST);
        check("rst_mw_stall", if_a.stall_cycles, 0);
        check("rst_mw_stall_b", if_b.stall_cycles, 0);
        rst = 1'b0;
        if_a.mem_dmem_req = 1'b0;
        #1 check("rst_mw_def", ctl_a(), V_DEF);
        tick();
        check("rst_mw_cnt", if_a.stall_cycles, 0);

        // watchdog restarts from zero after reset: three waits stay below TIMEOUT
        if_a.mem_dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_wd_fresh", if_a.mem_timeout, 0);
        tick();
        check("rst_wd_rise", if_a.mem_timeout, 1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipelined core.
- Combines three conditions into one prioritised set of enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - load-use hazard between ID and EX,
  - taken branch/jump resolved in EX,
  - data-memory wait in MEM.
- Adds a memory-wait watchdog and saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of each performance counter
TIMEOUT, 64, MEM_WAIT cycles before mem_timeout is raised (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active high
id_rs1  input  5  rs1 index of instruction in ID
id_rs2  input  5  rs2 index of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_mem_read  input  1  instruction in EX is a load
ex_reg_write  input  1  instruction in EX writes rd
ex_rd  input  5  destination index of instruction in EX
ex_branch_taken  input  1  EX resolved a taken branch/jump
mem_dmem_req  input  1  MEM stage accessing data memory
mem_dmem_ready  input  1  data memory completes access this cycle
cnt_clr  input  1  synchronous clear of counters and mem_timeout
pc_write  output  1  PC register load enable
if_id_enable  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID loads NOP
id_ex_enable  output  1  ID/EX register enable
id_ex_flush  output  1  ID/EX loads NOP (control bits zeroed)
ex_mem_enable  output  1  EX/MEM register enable
mem_wb_bubble  output  1  MEM/WB loads NOP
stall_cycles  output  CNT_W  saturating count of load-use and mem-wait cycles
flush_events  output  CNT_W  saturating count of branch flushes
mem_timeout  output  1  sticky: a MEM_WAIT lasted >= TIMEOUT cycles

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset: on a clk edge with rst=1, state<=RUN, wait_cnt<=0, counters<=0, mem_timeout<=0.
  - While rst=1, outputs are forced to: pc_write=0, if_id_enable=0, id_ex_enable=0, ex_mem_enable=0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
  - Reset mid-MEM_WAIT abandons the wait with no counter update.
- States: RUN, MEM_WAIT. Outputs are combinational from state and current inputs (zero latency).
- Default outputs (no event): all enables=1, pc_write=1, all flush/bubble=0.
- load_use = ex_mem_read & ex_reg_write & (ex_rd!=0) & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- mem_wait = mem_dmem_req & ~mem_dmem_ready.
- Priority in RUN (highest first):
  1. mem_wait: pc_write=0, if_id_enable=0, id_ex_enable=0, ex_mem_enable=0, mem_wb_bubble=1. Next state MEM_WAIT, wait_cnt<=1. Branch and load-use are ignored this cycle because EX is held and they re-present later.
  2. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1. flush_events+1. A simultaneous load_use is ignored, since the ID instruction is wrong-path.
  3. load_use: pc_write=0, if_id_enable=0, id_ex_flush=1. stall_cycles+1. Exactly one bubble per load, because the load leaves EX next cycle.
- MEM_WAIT: same freeze outputs as mem_wait.
  - stall_cycles increments every cycle spent in MEM_WAIT, plus the entry cycle.
  - wait_cnt increments, saturating at TIMEOUT. When wait_cnt reaches TIMEOUT, mem_timeout<=1 (sticky until cnt_clr or rst).
  - When mem_dmem_ready=1: that cycle outputs are default (the access completes and the pipeline advances), next state RUN, wait_cnt<=0. Branch and load-use are evaluated normally in that cycle under the RUN priority rules.
  - mem_dmem_req dropping without ready is illegal; the controller treats it as ready.
- Counters:
  - Saturate at all-ones with no wrap.
  - cnt_clr wins over a same-cycle increment.
  - cnt_clr does not affect state or wait_cnt.
- rd=x0 never causes a load-use stall. A hazard on both rs1 and rs2 gives a single bubble.

Test Plan:
- Load-use: load with ex_rd=5, id_rs1=5, id_uses_rs1=1 -> that cycle pc_write=0, if_id_enable=0, id_ex_flush=1. Next cycle (ex_mem_read=0) defaults. stall_cycles=1.
- x0/unused: ex_rd=0 with id_rs1=0, and separately ex_rd=7 with id_rs2=7 but id_uses_rs2=0 -> no stall, stall_cycles=0.
- Branch vs load-use same cycle: ex_branch_taken=1 with load_use true -> pc_write=1, if_id_flush=1, id_ex_flush=1. flush_events=1, stall_cycles=0.
- Mem wait: mem_dmem_req=1, ready low for 3 cycles then high -> 3 cycles all enables 0 and mem_wb_bubble=1. Ready cycle gives defaults. stall_cycles=3, state back to RUN.
- Watchdog: TIMEOUT=4, ready held low 6 cycles -> mem_timeout rises at the edge where wait_cnt=4 and stays 1 after ready. cnt_clr -> mem_timeout=0, counters=0.
- Saturation and reset: CNT_W=2, 5 load-use events -> stall_cycles=3. rst pulsed mid-MEM_WAIT -> forced reset outputs while high, then RUN with counters 0.
